// File: rtl/upscale_strip_scheduler.sv
// upscale_strip_scheduler: buffers 4x4 RGB blocks and bursts one strip per refill into the 4-row line buffer.
// One block is loaded every 4 cycles from the trigger; a starved strip is skipped so upstream stays strip-aligned.
module upscale_strip_scheduler #(
    parameter int FRAME_WIDTH  = 512,
    parameter int FRAME_HEIGHT = 512,
    parameter int H_ACTIVE     = 1280,
    parameter int V_TOTAL      = 750,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic [10:0]                       hcount_in,
    input  logic [9:0]                        vcount_in,
    input  logic [3:0][3:0][7:0]              r_blk_in,
    input  logic [3:0][3:0][7:0]              g_blk_in,
    input  logic [3:0][3:0][7:0]              b_blk_in,
    input  logic                              blk_valid_in,
    output logic                              blk_ready_out,
    output logic [3:0][3:0][7:0]              buf_r_out,
    output logic [3:0][3:0][7:0]              buf_g_out,
    output logic [3:0][3:0][7:0]              buf_b_out,
    output logic                              buf_valid_write_out,
    output logic                              buf_valid_read_addr_out,
    output logic                              frame_start_out,
    output logic [$clog2(FRAME_HEIGHT/4)-1:0] strip_idx_out,
    output logic                              busy_out,
    output logic                              underrun_out
);
    localparam int BLOCKS = FRAME_WIDTH / 4;
    localparam int BW = $clog2(BLOCKS);
    localparam int SW = $clog2(FRAME_HEIGHT / 4);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLOCKS - 1);
    localparam logic [PW:0] FIFO_FULL = (PW + 1)'(FIFO_DEPTH);
    localparam logic [10:0] H_TRIG = 11'(H_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [1:0] IDLE = 2'd0, BURST = 2'd1, SKIP = 2'd2;

    logic [1:0]    state_q, state_d, phase_q, phase_d;
    logic [BW-1:0] blk_cnt_q, blk_cnt_d;
    logic [PW:0]   count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [SW-1:0] strip_q, strip_d;
    logic          underrun_q, underrun_d, frame_start_q, frame_start_d, wr_q, wr_d;
    logic [383:0]  buf_q, buf_d;
    logic [383:0]  mem_q [FIFO_DEPTH];
    logic          trig_frame, trig_strip, avail, pop, push;
    logic [SW-1:0] strip_next;

    assign trig_frame = (hcount_in == H_TRIG) && (vcount_in == V_LAST);
    assign trig_strip = (hcount_in == H_TRIG) && (vcount_in[1:0] == 2'b11)
                        && (int'(vcount_in) + 1 < FRAME_HEIGHT);
    assign strip_next = SW'((int'(vcount_in) + 1) >> 2);
    assign avail = count_q != '0;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + 2'd1;
        blk_cnt_d = blk_cnt_q;
        strip_d = strip_q;
        underrun_d = underrun_q;
        frame_start_d = 1'b0;
        pop = 1'b0;
        if (state_q == IDLE) begin
            // The trigger cycle itself is phase 0, so its pop lands on the buffer at T+1.
            phase_d = 2'd1;
            if (trig_frame || trig_strip) begin
                strip_d = trig_frame ? '0 : strip_next;
                frame_start_d = trig_frame;
                pop = avail;
                blk_cnt_d = avail ? BW'(1) : '0;
                underrun_d = underrun_q || !avail;
                state_d = avail ? BURST : SKIP;
            end
        end else if (state_q == BURST) begin
            if (phase_q == 2'd0) begin
                pop = avail;
                blk_cnt_d = avail ? blk_cnt_q + BW'(1) : blk_cnt_q;
                underrun_d = underrun_q || !avail;
                state_d = !avail ? SKIP : (blk_cnt_q == BLK_LAST) ? IDLE : BURST;
            end
        end else if (blk_valid_in) begin
            blk_cnt_d = blk_cnt_q + BW'(1);
            state_d = (blk_cnt_q == BLK_LAST) ? IDLE : SKIP;
        end
    end

    // In SKIP every offered block is taken and dropped rather than queued.
    assign blk_ready_out = (count_q != FIFO_FULL) || pop || (state_q == SKIP);
    assign push = blk_valid_in && blk_ready_out && (state_q != SKIP);

    always_comb begin
        count_d = count_q + (PW + 1)'(push) - (PW + 1)'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        buf_d = pop ? mem_q[rd_ptr_q] : buf_q;
        wr_d = pop;
    end

    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr_q] <= {r_blk_in, g_blk_in, b_blk_in};
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            phase_q <= '0;
            blk_cnt_q <= '0;
            count_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            strip_q <= '0;
            underrun_q <= 1'b0;
            frame_start_q <= 1'b0;
            wr_q <= 1'b0;
            buf_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            blk_cnt_q <= blk_cnt_d;
            count_q <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            strip_q <= strip_d;
            underrun_q <= underrun_d;
            frame_start_q <= frame_start_d;
            wr_q <= wr_d;
            buf_q <= buf_d;
        end
    end

    assign {buf_r_out, buf_g_out, buf_b_out} = buf_q;
    assign buf_valid_write_out = wr_q;
    assign buf_valid_read_addr_out = (int'(hcount_in) < FRAME_WIDTH) && (int'(vcount_in) < FRAME_HEIGHT);
    assign frame_start_out = frame_start_q;
    assign strip_idx_out = strip_q;
    assign busy_out = state_q != IDLE;
    assign underrun_out = underrun_q;
endmodule
